// File: rtl/segre_dcache_refill_ctrl_if.sv
// rtl/segre_dcache_refill_ctrl_if.sv - pipeline, memory-side and fill signals of the dcache refill controller
interface segre_dcache_refill_ctrl_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int LINE_BYTES = 16,
    parameter int INDEX_SIZE = 2,
    parameter int TAG_SIZE   = 28
);
    logic                    req_i;
    logic [ADDR_SIZE-1:0]    addr_i;
    logic                    hit_i;
    logic                    miss_i;
    logic                    flush_i;
    logic                    stall_o;
    logic                    mem_rd_req_o;
    logic                    mem_gnt_i;
    logic [ADDR_SIZE-1:0]    mem_addr_o;
    logic                    mem_rvalid_i;
    logic [LINE_BYTES*8-1:0] mem_rdata_i;
    logic                    mmu_data_o;
    logic [INDEX_SIZE-1:0]   fill_index_o;
    logic [TAG_SIZE-1:0]     fill_tag_o;
    logic [LINE_BYTES*8-1:0] fill_data_o;
    logic                    busy_o;

    modport master (
        input  req_i, addr_i, hit_i, miss_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output stall_o, mem_rd_req_o, mem_addr_o, mmu_data_o, fill_index_o, fill_tag_o,
               fill_data_o, busy_o
    );

    modport slave (
        output req_i, addr_i, hit_i, miss_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  stall_o, mem_rd_req_o, mem_addr_o, mmu_data_o, fill_index_o, fill_tag_o,
               fill_data_o, busy_o
    );
endinterface

// File: rtl/segre_dcache_refill_ctrl.sv
// rtl/segre_dcache_refill_ctrl.sv - dcache miss handler: line fetch, fill strobe, round-robin victim
module segre_dcache_refill_ctrl #(
    parameter int ADDR_SIZE  = 32,
    parameter int LINE_BYTES = 16,
    parameter int NUM_LANES  = 4,
    parameter int INDEX_SIZE = 2,
    parameter int TAG_SIZE   = 28
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    segre_dcache_refill_ctrl_if.master bus
);
    localparam int OFFSET = $clog2(LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;

    state_e                state_q,  state_d;
    logic [TAG_SIZE-1:0]   tag_q,    tag_d;
    logic [INDEX_SIZE-1:0] victim_q, victim_d;
    logic [INDEX_SIZE-1:0] rr_ptr_q, rr_ptr_d;
    logic                  drop_q,   drop_d;
    logic [LINE_W-1:0]     data_q,   data_d;

    logic start_miss;
    logic fill_en;
    logic unused_ok;

    // Miss wins over a (illegal) simultaneous hit simply because hit_i is never consulted.
    assign start_miss = bus.req_i & bus.miss_i;
    assign fill_en    = (state_q == FILL) & ~drop_q & ~bus.flush_i;
    assign unused_ok  = ^{bus.hit_i, bus.addr_i[OFFSET-1:0]};

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        victim_d = victim_q;
        rr_ptr_d = rr_ptr_q;
        drop_d   = drop_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (start_miss) begin
                    tag_d    = bus.addr_i[ADDR_SIZE-1:OFFSET];
                    victim_d = rr_ptr_q;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.flush_i)   drop_d  = 1'b1;
                if (bus.mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush_i) drop_d = 1'b1;
                if (bus.mem_rvalid_i) begin
                    data_d  = bus.mem_rdata_i;
                    state_d = FILL;
                end
            end
            FILL: begin
                // A dropped line still consumes its victim slot.
                rr_ptr_d = (rr_ptr_q == INDEX_SIZE'(NUM_LANES - 1)) ? '0
                                                                     : rr_ptr_q + INDEX_SIZE'(1);
                drop_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            victim_q <= '0;
            rr_ptr_q <= '0;
            drop_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
            data_q   <= data_d;
        end
    end

    assign bus.stall_o      = rsn_i & ((state_q != IDLE) | start_miss);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.mem_rd_req_o = (state_q == REQ);
    assign bus.mem_addr_o   = (state_q == REQ) ? {tag_q, {OFFSET{1'b0}}} : '0;
    assign bus.mmu_data_o   = fill_en;
    assign bus.fill_index_o = fill_en ? victim_q : '0;
    assign bus.fill_tag_o   = fill_en ? tag_q    : '0;
    assign bus.fill_data_o  = fill_en ? data_q   : '0;
endmodule
